// File: rtl/riscv_pkg.sv
// Shared ALU control codes, datapath sizes and forwarding-select type for the integer pipeline.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int RADDR = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1110;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding select: picks MEM, then WB, then register-file data for one source index.
// Purely combinational; x0 never forwards.
module fwd_unit
  import riscv_pkg::*;
#(
  parameter int RADDR_W = RADDR
) (
  input  logic [RADDR_W-1:0] rs_i,
  input  logic [RADDR_W-1:0] mem_rd_i,
  input  logic               mem_reg_write_i,
  input  logic [RADDR_W-1:0] wb_rd_i,
  input  logic               wb_reg_write_i,
  output fwd_sel_t           sel_o
);

  logic rs_nz;
  assign rs_nz = (rs_i != '0);

  always_comb begin
    sel_o = FWD_REG;
    if (rs_nz && mem_reg_write_i && (mem_rd_i == rs_i)) begin
      sel_o = FWD_MEM;
    end else if (rs_nz && wb_reg_write_i && (wb_rd_i == rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with MEM/WB forwarding, load-use bubble, flush and hold.
// One cycle from capture to X/Y/CONTROL; forwarding is combinational on the registered indices.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN_W  = XLEN,
  parameter int RADDR_W = RADDR
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               id_valid_i,
  input  logic [XLEN_W-1:0]  id_pc_i,
  input  logic [RADDR_W-1:0] id_rs1_i,
  input  logic [RADDR_W-1:0] id_rs2_i,
  input  logic [XLEN_W-1:0]  id_rs1_data_i,
  input  logic [XLEN_W-1:0]  id_rs2_data_i,
  input  logic [XLEN_W-1:0]  id_imm_i,
  input  logic [RADDR_W-1:0] id_rd_i,
  input  logic [3:0]         id_alu_ctrl_i,
  input  logic               id_sel_x_i,
  input  logic               id_sel_y_i,
  input  logic               id_reg_write_i,
  input  logic               id_mem_read_i,
  input  logic [RADDR_W-1:0] mem_rd_i,
  input  logic               mem_reg_write_i,
  input  logic [XLEN_W-1:0]  mem_result_i,
  input  logic [RADDR_W-1:0] wb_rd_i,
  input  logic               wb_reg_write_i,
  input  logic [XLEN_W-1:0]  wb_data_i,
  input  logic               flush_i,
  input  logic               hold_i,
  output logic [XLEN_W-1:0]  x_o,
  output logic [XLEN_W-1:0]  y_o,
  output logic [3:0]         control_o,
  output logic               ex_valid_o,
  output logic [XLEN_W-1:0]  ex_pc_o,
  output logic [RADDR_W-1:0] ex_rd_o,
  output logic               ex_reg_write_o,
  output logic               ex_mem_read_o,
  output logic [XLEN_W-1:0]  ex_store_data_o,
  output logic               stall_o
);

  logic               valid_q, valid_d;
  logic [XLEN_W-1:0]  pc_q, pc_d;
  logic [RADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN_W-1:0]  rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN_W-1:0]  imm_q, imm_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic               sel_x_q, sel_x_d, sel_y_q, sel_y_d;
  logic               reg_write_q, reg_write_d, mem_read_q, mem_read_d;

  fwd_sel_t           fwd1_sel, fwd2_sel;
  logic [XLEN_W-1:0]  fwd_rs1, fwd_rs2;
  logic               load_use;

  fwd_unit #(.RADDR_W(RADDR_W)) u_fwd_rs1 (
    .rs_i            (rs1_q),
    .mem_rd_i        (mem_rd_i),
    .mem_reg_write_i (mem_reg_write_i),
    .wb_rd_i         (wb_rd_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .sel_o           (fwd1_sel)
  );

  fwd_unit #(.RADDR_W(RADDR_W)) u_fwd_rs2 (
    .rs_i            (rs2_q),
    .mem_rd_i        (mem_rd_i),
    .mem_reg_write_i (mem_reg_write_i),
    .wb_rd_i         (wb_rd_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .sel_o           (fwd2_sel)
  );

  always_comb begin
    case (fwd1_sel)
      FWD_MEM: fwd_rs1 = mem_result_i;
      FWD_WB:  fwd_rs1 = wb_data_i;
      default: fwd_rs1 = rs1_data_q;
    endcase
    case (fwd2_sel)
      FWD_MEM: fwd_rs2 = mem_result_i;
      FWD_WB:  fwd_rs2 = wb_data_i;
      default: fwd_rs2 = rs2_data_q;
    endcase
  end

  // Conservative: any index match stalls, even if the consumer ignores rs2.
  assign load_use = valid_q && mem_read_q && (rd_q != '0) && id_valid_i &&
                    ((rd_q == id_rs1_i) || (rd_q == id_rs2_i));
  assign stall_o  = load_use && !flush_i && !hold_i;

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    ctrl_d      = ctrl_q;
    sel_x_d     = sel_x_q;
    sel_y_d     = sel_y_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (flush_i || (!hold_i && load_use)) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      ctrl_d      = ALU_ADD;
    end else if (hold_i) begin
      // Re-sample forwarded operands so a value survives its producer leaving WB.
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
    end else begin
      valid_d     = id_valid_i;
      pc_d        = id_pc_i;
      rs1_d       = id_rs1_i;
      rs2_d       = id_rs2_i;
      rs1_data_d  = id_rs1_data_i;
      rs2_data_d  = id_rs2_data_i;
      imm_d       = id_imm_i;
      rd_d        = id_rd_i;
      ctrl_d      = id_alu_ctrl_i;
      sel_x_d     = id_sel_x_i;
      sel_y_d     = id_sel_y_i;
      reg_write_d = id_reg_write_i;
      mem_read_d  = id_mem_read_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      ctrl_q      <= ALU_ADD;
      sel_x_q     <= 1'b0;
      sel_y_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      ctrl_q      <= ctrl_d;
      sel_x_q     <= sel_x_d;
      sel_y_q     <= sel_y_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  assign x_o             = sel_x_q ? pc_q : fwd_rs1;
  assign y_o             = sel_y_q ? imm_q : fwd_rs2;
  assign control_o       = ctrl_q;
  assign ex_valid_o      = valid_q;
  assign ex_pc_o         = pc_q;
  assign ex_rd_o         = rd_q;
  assign ex_reg_write_o  = reg_write_q;
  assign ex_mem_read_o   = mem_read_q;
  assign ex_store_data_o = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, x0 guard, load-use, flush, hold refresh.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_sel_x, id_sel_y, id_reg_write, id_mem_read;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_data;
  logic        flush, hold;
  logic [31:0] x, y, ex_pc, ex_store_data;
  logic [3:0]  control;
  logic        ex_valid, ex_reg_write, ex_mem_read, stall;
  logic [4:0]  ex_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .reset_i(reset),
    .id_valid_i(id_valid), .id_pc_i(id_pc), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
    .id_rd_i(id_rd), .id_alu_ctrl_i(id_alu_ctrl), .id_sel_x_i(id_sel_x), .id_sel_y_i(id_sel_y),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
    .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write), .mem_result_i(mem_result),
    .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write), .wb_data_i(wb_data),
    .flush_i(flush), .hold_i(hold),
    .x_o(x), .y_o(y), .control_o(control),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_rd_o(ex_rd),
    .ex_reg_write_o(ex_reg_write), .ex_mem_read_o(ex_mem_read),
    .ex_store_data_o(ex_store_data), .stall_o(stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [4:0] rd, input logic [3:0] ctrl, input logic sx,
                        input logic sy, input logic rw, input logic mr);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_rd = rd;
    id_alu_ctrl = ctrl; id_sel_x = sx; id_sel_y = sy; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic clr_fwd();
    mem_rd = 5'd0; mem_reg_write = 1'b0; mem_result = 32'h0;
    wb_rd = 5'd0; wb_reg_write = 1'b0; wb_data = 32'h0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
    clr_fwd();
    // 1: reset with a valid load presented
    set_id(32'h10, 5'd7, 5'd7, 32'h1, 32'h2, 32'h3, 5'd7, ALU_SUB, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    #1;
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_ctrl", {28'b0, control}, 32'd0);
    chk("rst_x", x, 32'h0);
    chk("rst_y", y, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_rw", {31'b0, ex_reg_write}, 32'd0);
    reset = 1'b0;

    // 2: MEM beats WB on the same rs1
    set_id(32'h100, 5'd5, 5'd6, 32'h11, 32'h22, 32'h40, 5'd9, ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    id_valid = 1'b0;
    mem_rd = 5'd5; mem_reg_write = 1'b1; mem_result = 32'h1234;
    wb_rd = 5'd5; wb_reg_write = 1'b1; wb_data = 32'hBEEF;
    #1;
    chk("fwd_mem_x", x, 32'h1234);
    chk("fwd_y_reg", y, 32'h22);
    chk("fwd_ctrl", {28'b0, control}, 32'h7);
    chk("fwd_pc", ex_pc, 32'h100);
    chk("fwd_rd", {27'b0, ex_rd}, 32'd9);
    chk("fwd_store", ex_store_data, 32'h22);
    mem_reg_write = 1'b0;
    #1;
    chk("fwd_wb_x", x, 32'hBEEF);
    wb_reg_write = 1'b0;
    #1;
    chk("fwd_reg_x", x, 32'h11);

    // 3: x0 never forwards; then PC/imm selection with forwarded store data
    set_id(32'h180, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 5'd1, ALU_AND, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    id_valid = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'hFFFF;
    wb_rd = 5'd0; wb_reg_write = 1'b1; wb_data = 32'h77;
    #1;
    chk("x0_y", y, 32'h0);
    chk("x0_x", x, 32'h0);
    chk("x0_store", ex_store_data, 32'h0);
    clr_fwd();
    set_id(32'h200, 5'd1, 5'd2, 32'h9, 32'h33, 32'hFFFFF800, 5'd3, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    id_valid = 1'b0;
    mem_rd = 5'd2; mem_reg_write = 1'b1; mem_result = 32'h55;
    #1;
    chk("selx_pc", x, 32'h200);
    chk("sely_imm", y, 32'hFFFFF800);
    chk("store_fwd", ex_store_data, 32'h55);
    clr_fwd();

    // 4: lw x7 in EX, add x8,x7,x1 in ID
    set_id(32'h300, 5'd2, 5'd0, 32'h1000, 32'h0, 32'h4, 5'd7, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    set_id(32'h304, 5'd7, 5'd1, 32'hDEAD, 32'h5, 32'h0, 5'd8, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("lu_stall", {31'b0, stall}, 32'd1);
    chk("lu_memrd", {31'b0, ex_mem_read}, 32'd1);
    chk("lu_ld_y", y, 32'h4);
    hold = 1'b1;
    #1;
    chk("lu_hold_gate", {31'b0, stall}, 32'd0);
    hold = 1'b0;
    tick();
    mem_rd = 5'd7; mem_reg_write = 1'b1; mem_result = 32'hCAFE;
    #1;
    chk("bub_valid", {31'b0, ex_valid}, 32'd0);
    chk("bub_rw", {31'b0, ex_reg_write}, 32'd0);
    chk("bub_stall", {31'b0, stall}, 32'd0);
    tick();
    id_valid = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0; mem_result = 32'h0;
    wb_rd = 5'd7; wb_reg_write = 1'b1; wb_data = 32'hCAFE;
    #1;
    chk("add_valid", {31'b0, ex_valid}, 32'd1);
    chk("add_rd", {27'b0, ex_rd}, 32'd8);
    chk("add_x", x, 32'hCAFE);
    chk("add_y", y, 32'h5);
    chk("add_stall", {31'b0, stall}, 32'd0);
    clr_fwd();

    // 5: flush with HOLD high, over a load-use pair
    set_id(32'h380, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 5'd7, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    set_id(32'h384, 5'd7, 5'd3, 32'h0, 32'h0, 32'h0, 5'd4, ALU_OR, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("fl_pre_stall", {31'b0, stall}, 32'd1);
    flush = 1'b1; hold = 1'b1;
    #1;
    chk("fl_stall", {31'b0, stall}, 32'd0);
    tick();
    flush = 1'b0; hold = 1'b0; id_valid = 1'b0;
    #1;
    chk("fl_valid", {31'b0, ex_valid}, 32'd0);
    chk("fl_rw", {31'b0, ex_reg_write}, 32'd0);
    chk("fl_mr", {31'b0, ex_mem_read}, 32'd0);
    chk("fl_ctrl", {28'b0, control}, 32'd0);

    // 6: WB-forwarded operand kept alive through HOLD
    set_id(32'h400, 5'd3, 5'd4, 32'h1111, 32'h44, 32'h0, 5'd10, ALU_XOR, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(32'h500, 5'd6, 5'd6, 32'h0, 32'h0, 32'h0, 5'd11, ALU_OR, 1'b0, 1'b0, 1'b1, 1'b0);
    wb_rd = 5'd3; wb_reg_write = 1'b1; wb_data = 32'hA5A5;
    hold = 1'b1;
    #1;
    chk("hold_x0", x, 32'hA5A5);
    tick();
    wb_reg_write = 1'b0;
    #1;
    chk("hold_x1", x, 32'hA5A5);
    tick(); tick();
    #1;
    chk("hold_x3", x, 32'hA5A5);
    chk("hold_y", y, 32'h44);
    chk("hold_pc", ex_pc, 32'h400);
    chk("hold_rd", {27'b0, ex_rd}, 32'd10);
    chk("hold_ctrl", {28'b0, control}, 32'h9);
    chk("hold_valid", {31'b0, ex_valid}, 32'd1);
    chk("hold_rw", {31'b0, ex_reg_write}, 32'd1);
    chk("hold_stall", {31'b0, stall}, 32'd0);
    hold = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
